// File: rtl/timerio_pkg.sv
// Shared constants for the timerio interval timer: register offsets,
// CTRL/STAT bit positions and prescaler encodings.
package timerio_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_RELH = 3'd2;
  localparam logic [2:0] REG_RELL = 3'd3;
  localparam logic [2:0] REG_CNTH = 3'd4;
  localparam logic [2:0] REG_CNTL = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQEN  = 2;
  localparam int CTRL_PS_LSB = 4;

  localparam int STAT_TOF = 0;
  localparam int STAT_RUN = 1;

  typedef enum logic [1:0] {
    PS_DIV1   = 2'b00,
    PS_DIV8   = 2'b01,
    PS_DIV64  = 2'b10,
    PS_DIV256 = 2'b11
  } ps_e;

  function automatic int unsigned ps_divide(input ps_e ps);
    case (ps)
      PS_DIV1:   return 1;
      PS_DIV8:   return 8;
      PS_DIV64:  return 64;
      PS_DIV256: return 256;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/timerio_if.sv
// CPU-side bus of the timerio block: register select, data in/out,
// read/write strobe, chip select and the level interrupt.
interface timerio_if;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;

  modport master (output AD, DI, rw, cs, input DO, irq);
  modport slave  (input AD, DI, rw, cs, output DO, irq);
endinterface

// File: rtl/timerio_prescaler.sv
// Tick generator for the timerio counter. With TIMERIO_PRESCALER_EN defined a
// counter divides by 1/8/64/256; otherwise every enabled cycle is a tick.
module timerio_prescaler
  import timerio_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] ps,
  output logic       tick
);

`ifdef TIMERIO_PRESCALER_EN
  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] last;

  assign last = PRESC_W'(ps_divide(ps_e'(ps)) - 1);
  assign tick = en && (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end
`else
  logic unused_presc;
  assign unused_presc = ^{clk, rst, clr, ps, PRESC_W[0]};
  assign tick = en;
`endif

endmodule

// File: rtl/timerio.sv
// timerio: 16-bit down-counting interval timer on the 6801 I/O bus with
// auto-reload, one-shot mode and level IRQ. Prescaler gated by TIMERIO_PRESCALER_EN.
module timerio
  import timerio_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input logic       clk,
  input logic       rst,
  timerio_if.slave  bus
);

  logic        ctrl_en;
  logic        ctrl_auto;
  logic        ctrl_irqen;
  logic [1:0]  ps_q;
  logic        tof;
  logic [7:0]  hold;
  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  clat;
  logic [7:0]  rdata;

  logic wr, rd, ctrl_wr, en_rise, stat_w1c, tick, timeout;

  assign wr       = bus.cs && !bus.rw;
  assign rd       = bus.cs && bus.rw;
  assign ctrl_wr  = wr && (bus.AD == REG_CTRL);
  assign en_rise  = ctrl_wr && bus.DI[CTRL_EN] && !ctrl_en;
  assign stat_w1c = wr && (bus.AD == REG_STAT) && bus.DI[STAT_TOF];
  assign timeout  = tick && (count == 16'd0);

`ifdef TIMERIO_PRESCALER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= 2'b00;
    end else if (ctrl_wr) begin
      ps_q <= bus.DI[CTRL_PS_LSB +: 2];
    end
  end
`else
  assign ps_q = PS_DIV1;
`endif

  timerio_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_en),
    .clr  (en_rise),
    .ps   (ps_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_irqen <= 1'b0;
      tof        <= 1'b0;
      hold       <= 8'h00;
      reload     <= 16'h0000;
      count      <= 16'h0000;
      clat       <= 8'h00;
    end else begin
      // A CPU write to CTRL overrides the one-shot self-disable.
      if (ctrl_wr) begin
        ctrl_en    <= bus.DI[CTRL_EN];
        ctrl_auto  <= bus.DI[CTRL_AUTO];
        ctrl_irqen <= bus.DI[CTRL_IRQEN];
      end else if (timeout && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end
      if (wr && (bus.AD == REG_RELH)) hold <= bus.DI;
      if (wr && (bus.AD == REG_RELL)) reload <= {hold, bus.DI};
      if (rd && (bus.AD == REG_CNTH)) clat <= count[7:0];
      if (timeout) begin
        tof <= 1'b1;
      end else if (stat_w1c) begin
        tof <= 1'b0;
      end
      // Reload uses the pre-edge RELOAD, so a same-cycle RELL write applies next time.
      if (en_rise) begin
        count <= reload;
      end else if (tick) begin
        if (count != 16'd0) begin
          count <= count - 16'd1;
        end else if (ctrl_auto) begin
          count <= reload;
        end
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.AD)
      REG_CTRL: begin
        rdata[CTRL_EN]    = ctrl_en;
        rdata[CTRL_AUTO]  = ctrl_auto;
        rdata[CTRL_IRQEN] = ctrl_irqen;
`ifdef TIMERIO_PRESCALER_EN
        rdata[CTRL_PS_LSB +: 2] = ps_q;
`endif
      end
      REG_STAT: begin
        rdata[STAT_TOF] = tof;
        rdata[STAT_RUN] = ctrl_en;
      end
      REG_RELH: rdata = reload[15:8];
      REG_RELL: rdata = reload[7:0];
      REG_CNTH: rdata = count[15:8];
      REG_CNTL: rdata = clat;
      default:  rdata = 8'h00;
    endcase
  end

  assign bus.DO  = rdata;
  assign bus.irq = tof & ctrl_irqen;

endmodule

// File: tb/tb_timerio.sv
// Scoreboard bench for timerio: stimulus tasks queue expected DO/irq values,
// a negedge monitor pops and compares them.
module tb_timerio;
  import timerio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timerio_if bus ();

  timerio #(.PRESC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_irq;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  chk_t       cur;
  logic [7:0] act;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_checks++;
      act = cur.is_irq ? {7'b0, bus.irq} : bus.DO;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    bus.AD = 3'd0;
    bus.DI = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step();
    bus.cs = 1'b1;
    bus.rw = 1'b0;
    bus.AD = a;
    bus.DI = d;
  endtask

  task automatic push_do(input logic [7:0] e, input string nm);
    sb_q.push_back('{is_irq: 1'b0, exp: e, name: nm});
  endtask

  task automatic push_irq(input logic e, input string nm);
    sb_q.push_back('{is_irq: 1'b1, exp: {7'b0, e}, name: nm});
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    step();
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.AD = a;
    push_do(e, nm);
  endtask

  task automatic chk_irq(input logic e, input string nm);
    step();
    push_irq(e, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    bus.AD = 3'd0;
    bus.DI = 8'h00;
    idle(3);
    step();
    rst = 1'b1;

    // Reset values
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, $sformatf("reset reg%0d", i));
    chk_irq(1'b0, "reset irq");

    // Auto-reload, RELOAD=3, /1, IRQEN
    wr(REG_RELH, 8'h00);
    wr(REG_RELL, 8'h03);
    wr(REG_CTRL, 8'h07);
    idle(3);
    chk_irq(1'b0, "auto irq before timeout");
    chk_irq(1'b1, "auto irq at N+4");
    wr(REG_STAT, 8'h01);
    rd(REG_STAT, 8'h02, "auto stat after w1c");
    chk_irq(1'b0, "auto irq cleared");
    chk_irq(1'b1, "auto irq reassert");
    idle(1);
    wr(REG_STAT, 8'h01);
    wr(REG_STAT, 8'h01);
    rd(REG_STAT, 8'h03, "w1c on timeout cycle");
    wr(REG_CTRL, 8'h00);
    wr(REG_STAT, 8'h01);

    // One-shot, RELOAD=2
    wr(REG_RELH, 8'h00);
    wr(REG_RELL, 8'h02);
    wr(REG_CTRL, 8'h01);
    idle(2);
    rd(REG_STAT, 8'h02, "oneshot stat before");
    rd(REG_STAT, 8'h01, "oneshot stat tof");
    chk_irq(1'b0, "oneshot irq masked");
    rd(REG_CNTH, 8'h00, "oneshot cnth");
    rd(REG_CNTL, 8'h00, "oneshot cntl");
    idle(5);
    rd(REG_CNTH, 8'h00, "oneshot cnth hold");
    rd(REG_CNTL, 8'h00, "oneshot cntl hold");
    rd(REG_CTRL, 8'h00, "oneshot en cleared");
    wr(REG_STAT, 8'h01);

    // RELOAD=1, AUTO, PS=/8
    wr(REG_RELH, 8'h00);
    wr(REG_RELL, 8'h01);
    wr(REG_CTRL, 8'h13);
`ifdef TIMERIO_PRESCALER_EN
    rd(REG_CTRL, 8'h13, "ps ctrl readback");
    idle(14);
    rd(REG_STAT, 8'h02, "ps stat before");
    rd(REG_STAT, 8'h03, "ps first tof");
    wr(REG_STAT, 8'h01);
    idle(13);
    rd(REG_STAT, 8'h02, "ps stat period-1");
    rd(REG_STAT, 8'h03, "ps second tof");
`else
    rd(REG_CTRL, 8'h03, "nops ctrl readback");
    rd(REG_STAT, 8'h02, "nops stat before");
    wr(REG_STAT, 8'h01);
    rd(REG_STAT, 8'h02, "nops stat cleared");
    rd(REG_STAT, 8'h03, "nops second tof");
`endif
    wr(REG_CTRL, 8'h00);
    wr(REG_STAT, 8'h01);

    // Count latch across 0x0100 -> 0x00FF, then freeze
    wr(REG_RELH, 8'h01);
    wr(REG_RELL, 8'h00);
    wr(REG_CTRL, 8'h01);
    rd(REG_CNTH, 8'h01, "latch cnth");
    rd(REG_CNTL, 8'h00, "latch cntl");
    rd(REG_CNTH, 8'h00, "latch cnth 2");
    rd(REG_CNTL, 8'hFE, "latch cntl 2");
    wr(REG_CTRL, 8'h00);
    idle(3);
    rd(REG_CNTH, 8'h00, "frozen cnth");
    rd(REG_CNTL, 8'hFB, "frozen cntl");

    // RELL write on a reload edge, then async reset mid-count
    wr(REG_RELH, 8'h00);
    wr(REG_RELL, 8'h03);
    wr(REG_CTRL, 8'h07);
    idle(4);
    chk_irq(1'b1, "reload irq");
    idle(1);
    wr(REG_RELH, 8'h02);
    wr(REG_RELL, 8'h03);
    rd(REG_CNTH, 8'h00, "old reload cnth");
    rd(REG_CNTL, 8'h03, "old reload cntl");
    rd(REG_RELH, 8'h02, "new relh");
    idle(1);
    rd(REG_CNTH, 8'h02, "new reload cnth");
    rd(REG_CNTL, 8'h03, "new reload cntl");
    chk_irq(1'b1, "irq before reset");
    step();
    rst = 1'b0;
    push_irq(1'b0, "irq in reset");
    push_do(8'h00, "ctrl in reset");
    rd(REG_CNTH, 8'h00, "cnth in reset");
    rd(REG_RELH, 8'h00, "relh in reset");
    rd(REG_STAT, 8'h00, "stat in reset");
    step();
    rst = 1'b1;
    rd(REG_CNTL, 8'h00, "cntl after reset");
    chk_irq(1'b0, "irq after reset");

    idle(2);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
